cam_stream_gen: RTL and testbench

// - Camera-side transmitter for the capture FIFO: emits a synthetic OV7670-style byte stream (vsync, href, 8-bit data).
// - Drives the FIFO's href/vsync/din inputs on the board without a sensor.
// - Write strobe downstream = href & ~vsync; one byte per pix_en tick; RGB565 pixels sent high byte first.

---
 rtl/cam_pkg.sv | 29 ++
 rtl/cam_pattern_gen.sv | 35 +++
 rtl/cam_stream_gen.sv | 180 ++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the synthetic camera stream generator
package cam_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBACK,
      ACTIVE,
      HBLANK,
      VFRONT
   } state_t;

   localparam logic [1:0] PAT_RAMP  = 2'd0;
   localparam logic [1:0] PAT_BARS  = 2'd1;
   localparam logic [1:0] PAT_SOLID = 2'd2;
   localparam logic [1:0] PAT_ROW   = 2'd3;

   // RGB565 colour bars, left to right
   localparam logic [15:0] BAR_RGB [0:7] = '{
      16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
      16'hF81F, 16'hF800, 16'h001F, 16'h0000
   };

   // Bits needed to hold 0..max_count-1, never less than one
   function automatic int cnt_width(input int max_count);
      return (max_count <= 1) ? 1 : $clog2(max_count);
   endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// rtl/cam_pattern_gen.sv - combinational test-pattern byte for a given pattern, byte column and row
module cam_pattern_gen
   import cam_pkg::*;
#(
   parameter int          H_ACTIVE = 8,
   parameter int          COL_W    = 4,
   parameter int          ROW_W    = 1,
   parameter logic [15:0] SOLID    = 16'hF800
) (
   input  logic [1:0]       i_pat,
   input  logic [COL_W-1:0] i_col,
   input  logic [ROW_W-1:0] i_row,
   output logic [7:0]       o_byte
);

   logic [2:0]  w_bar;
   logic [15:0] w_rgb;

   always_comb begin
      w_bar  = 3'((32'(i_col) >> 1) / (H_ACTIVE / 8));
      w_rgb  = 16'h0000;
      o_byte = 8'h00;
      case (i_pat)
         PAT_RAMP:  o_byte = 8'(i_col);
         PAT_BARS:  w_rgb  = BAR_RGB[w_bar];
         PAT_SOLID: w_rgb  = SOLID;
         default:   o_byte = 8'(i_row);
      endcase
      // RGB565 goes out high byte on even columns, low byte on odd
      if (i_pat == PAT_BARS || i_pat == PAT_SOLID) begin
         o_byte = i_col[0] ? w_rgb[7:0] : w_rgb[15:8];
      end
   end

endmodule

// File: rtl/cam_stream_gen.sv
// rtl/cam_stream_gen.sv - synthetic OV7670-style vsync/href/byte stream source for the capture FIFO
module cam_stream_gen
   import cam_pkg::*;
#(
   parameter int          H_ACTIVE  = 8,
   parameter int          V_ACTIVE  = 2,
   parameter int          H_BLANK   = 3,
   parameter int          VSYNC_LEN = 2,
   parameter int          V_BACK    = 2,
   parameter int          V_FRONT   = 1,
   parameter logic [15:0] SOLID     = 16'hF800
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   input  logic       enable,
   input  logic [1:0] pattern,
   input  logic       fifo_full,
   output logic       vsync,
   output logic       href,
   output logic [7:0] dout,
   output logic       frame_done,
   output logic       overrun
);

   localparam int LINE_BYTES = 2 * H_ACTIVE;
   localparam int GAP_A      = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
   localparam int GAP_B      = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
   localparam int GAP_MAX    = (GAP_A > GAP_B) ? GAP_A : GAP_B;
   localparam int COL_W      = cnt_width(LINE_BYTES);
   localparam int CNT_W      = cnt_width(GAP_MAX);
   localparam int ROW_W      = cnt_width(V_ACTIVE);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_BYTES - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VSYNC_LEN - 1);
   localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(V_BACK - 1);
   localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] VF_LAST  = CNT_W'(V_FRONT - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [1:0]       r_pat;
   logic             r_vsync;
   logic             r_href;
   logic [7:0]       r_dout;
   logic             r_frame_done;
   logic             r_overrun;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [COL_W-1:0] w_col_nxt;
   logic [ROW_W-1:0] w_row_nxt;
   logic [1:0]       w_pat_nxt;
   logic             w_start;
   logic             w_frame_done_nxt;
   logic [7:0]       w_byte;

   // The byte is looked up from next-cycle col/row so it lands with href
   cam_pattern_gen #(
      .H_ACTIVE(H_ACTIVE),
      .COL_W   (COL_W),
      .ROW_W   (ROW_W),
      .SOLID   (SOLID)
   ) u_pattern (
      .i_pat (w_pat_nxt),
      .i_col (w_col_nxt),
      .i_row (w_row_nxt),
      .o_byte(w_byte)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_col_nxt   = r_col;
      w_row_nxt   = r_row;
      w_pat_nxt   = r_pat;
      w_start     = 1'b0;
      case (r_state)
         IDLE: w_start = enable;
         VSYNC: begin
            if (r_cnt == VS_LAST) begin
               w_state_nxt = VBACK;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         VBACK: begin
            if (r_cnt == VB_LAST) begin
               w_state_nxt = ACTIVE;
               w_cnt_nxt   = '0;
               w_col_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ACTIVE: begin
            if (r_col == COL_LAST) begin
               w_state_nxt = HBLANK;
               w_col_nxt   = '0;
               w_cnt_nxt   = '0;
            end else begin
               w_col_nxt = r_col + COL_W'(1);
            end
         end
         HBLANK: begin
            if (r_cnt != HB_LAST) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end else if (r_row != ROW_LAST) begin
               w_state_nxt = ACTIVE;
               w_row_nxt   = r_row + ROW_W'(1);
               w_col_nxt   = '0;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = VFRONT;
               w_cnt_nxt   = '0;
            end
         end
         VFRONT: begin
            if (r_cnt != VF_LAST) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end else if (enable) begin
               w_start = 1'b1;
            end else begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Frame start: the only place the pattern selection is taken
      if (w_start) begin
         w_state_nxt = VSYNC;
         w_cnt_nxt   = '0;
         w_col_nxt   = '0;
         w_row_nxt   = '0;
         w_pat_nxt   = pattern;
      end
      w_frame_done_nxt = (w_state_nxt == VFRONT) && (w_cnt_nxt == VF_LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_pat        <= PAT_RAMP;
         r_vsync      <= 1'b0;
         r_href       <= 1'b0;
         r_dout       <= 8'h00;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (pix_en) begin
            r_overrun    <= r_overrun | (r_href & fifo_full);
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_pat        <= w_pat_nxt;
            r_vsync      <= (w_state_nxt == VSYNC);
            r_href       <= (w_state_nxt == ACTIVE);
            r_dout       <= (w_state_nxt == ACTIVE) ? w_byte : 8'h00;
            r_frame_done <= w_frame_done_nxt;
         end
      end
   end

   assign vsync      = r_vsync;
   assign href       = r_href;
   assign dout       = r_dout;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_cam_stream_gen.sv
// tb/tb_cam_stream_gen.sv - self-checking bench for cam_stream_gen against a frame-position model
module tb_cam_stream_gen;

   localparam int VS   = 2;
   localparam int VB   = 2;
   localparam int HA   = 8;
   localparam int LB   = 2 * HA;
   localparam int HB   = 3;
   localparam int VA   = 2;
   localparam int VF   = 1;
   localparam int FLEN = VS + VB + VA * (LB + HB) + VF;
   localparam int BARS [8] = '{'hFFFF, 'hFFE0, 'h07FF, 'h07E0, 'hF81F, 'hF800, 'h001F, 'h0000};
   localparam int BARS_LINE [16] = '{'hFF, 'hFF, 'hFF, 'hE0, 'h07, 'hFF, 'h07, 'hE0,
                                     'hF8, 'h1F, 'hF8, 'h00, 'h00, 'h1F, 'h00, 'h00};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pix_en = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] pattern = 2'd0;
   logic       fifo_full = 1'b0;
   logic       vsync, href, frame_done, overrun;
   logic [7:0] dout;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   cam_stream_gen dut (
      .clk       (clk),
      .reset     (reset),
      .pix_en    (pix_en),
      .enable    (enable),
      .pattern   (pattern),
      .fifo_full (fifo_full),
      .vsync     (vsync),
      .href      (href),
      .dout      (dout),
      .frame_done(frame_done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   function automatic int exp_byte(input int pat, input int k, input int line);
      int colr;
      colr = 0;
      case (pat)
         0: return k & 255;
         1: colr = BARS[(k / 2) / (HA / 8)];
         2: colr = 'hF800;
         default: return line & 255;
      endcase
      return (k % 2 == 1) ? (colr & 255) : ((colr >> 8) & 255);
   endfunction

   // {vsync, href, dout, frame_done, overrun} at a 1-based tick position in the frame
   function automatic logic [11:0] model_out(input bit idle, input int pos, input int pat,
                                             input bit ticked, input bit ovr);
      logic v, h, fd;
      int d, p, line, k;
      v = 1'b0; h = 1'b0; fd = 1'b0; d = 0;
      if (!idle) begin
         if (pos <= VS) begin
            v = 1'b1;
         end else if (pos > VS + VB) begin
            p = pos - VS - VB - 1;
            if (p < VA * (LB + HB)) begin
               line = p / (LB + HB);
               k    = p % (LB + HB);
               if (k < LB) begin
                  h = 1'b1;
                  d = exp_byte(pat, k, line);
               end
            end
         end
         fd = (pos == FLEN) && ticked;
      end
      return {v, h, 8'(d), fd, ovr};
   endfunction

   bit m_idle = 1'b1;
   int m_pos = 0;
   int m_pat = 0;
   bit m_ticked = 1'b0;
   bit m_ovr = 1'b0;

   always @(posedge clk) begin : model
      logic [11:0] cur;
      cur = model_out(m_idle, m_pos, m_pat, 1'b0, 1'b0);
      if (!reset) begin
         m_idle   <= 1'b1;
         m_pos    <= 0;
         m_ticked <= 1'b0;
         m_ovr    <= 1'b0;
      end else begin
         m_ticked <= pix_en;
         if (pix_en) begin
            if (cur[10] && fifo_full) m_ovr <= 1'b1;
            if (m_idle || m_pos == FLEN) begin
               if (enable) begin
                  m_idle <= 1'b0;
                  m_pos  <= 1;
                  m_pat  <= int'(pattern);
               end else begin
                  m_idle <= 1'b1;
                  m_pos  <= 0;
               end
            end else begin
               m_pos <= m_pos + 1;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [11:0] e, a;
      if (cmp_en) begin
         e = model_out(m_idle, m_pos, m_pat, m_ticked, m_ovr);
         a = {vsync, href, dout, frame_done, overrun};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL stream @%0t: dut v=%b h=%b d=%02h fd=%b ov=%b, expected v=%b h=%b d=%02h fd=%b ov=%b",
                     $time, a[11], a[10], a[9:2], a[1], a[0], e[11], e[10], e[9:2], e[1], e[0]);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0: return vsync;
         1: return href;
         default: return frame_done;
      endcase
   endfunction

   task automatic wait_sig(input string name, input int which, input logic val, input int bound);
      int n;
      n = 0;
      while (sig(which) !== val && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(sig(which) === val), 1);
   endtask

   task automatic run_cycles(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         case (mode)
            0: pix_en = 1'b1;
            1: pix_en = (i % 3 == 0);
            default: pix_en = ($urandom_range(0, 99) < 70);
         endcase
      end
   endtask

   initial begin : stim
      int fd_tick;
      for (int k = 0; k < 16; k++) chk($sformatf("pin_bars_%0d", k), exp_byte(1, k, 0), BARS_LINE[k]);
      chk("pin_row1", exp_byte(3, 7, 1), 1);
      chk("pin_first_active", int'(model_out(1'b0, 5, 0, 1'b1, 1'b0)), 'b0100_0000_0000);
      chk("pin_last_byte", int'(model_out(1'b0, 20, 0, 1'b1, 1'b0)), 'b0100_0011_1100);
      chk("pin_frame_done", int'(model_out(1'b0, 43, 0, 1'b1, 1'b0)), 'b0000_0000_0010);

      reset = 1'b0; enable = 1'b1; pattern = 2'd0; pix_en = 1'b1;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_vsync", vsync, 0);
      chk("rst_href", href, 0);
      chk("rst_dout", dout, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b1;

      fd_tick = 0;
      for (int t = 1; t <= 44; t++) begin
         @(negedge clk);
         if (t == 1) chk("vsync_after_release", vsync, 1);
         if (t == 5) chk("first_byte_href", href, 1);
         if (frame_done && fd_tick == 0) fd_tick = t;
         if (t == 44) chk("vsync_next_frame", vsync, 1);
      end
      chk("frame_done_tick", fd_tick, 43);

      pattern = 2'd1; run_cycles(90, 0);
      pattern = 2'd3; run_cycles(90, 0);
      pattern = 2'd1; run_cycles(270, 1);
      pattern = 2'd2; run_cycles(270, 1);
      pattern = 2'd1; pix_en = 1'b1;

      wait_sig("wait_vsync", 0, 1'b1, 200);
      wait_sig("wait_line0", 1, 1'b1, 50);
      repeat (4) @(negedge clk);
      enable = 1'b0; pattern = 2'd3;
      wait_sig("disable_frame_done", 2, 1'b1, 100);
      run_cycles(20, 0);
      chk("idle_vsync", vsync, 0);
      chk("idle_href", href, 0);
      chk("idle_dout", dout, 0);
      enable = 1'b1;
      run_cycles(50, 0);

      wait_sig("ovr_wait_href", 1, 1'b1, 60);
      wait_sig("ovr_wait_hblank", 1, 1'b0, 60);
      fifo_full = 1'b1;
      repeat (3) @(negedge clk);
      fifo_full = 1'b0;
      chk("ovr_hblank_only", overrun, 0);
      wait_sig("ovr_wait_active", 1, 1'b1, 60);
      fifo_full = 1'b1;
      @(negedge clk);
      fifo_full = 1'b0;
      chk("ovr_set", overrun, 1);
      run_cycles(60, 0);
      chk("ovr_sticky", overrun, 1);
      reset = 1'b0;
      @(negedge clk);
      chk("ovr_cleared_by_reset", overrun, 0);
      reset = 1'b1;

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         pix_en    = ($urandom_range(0, 99) < 70);
         fifo_full = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 49) == 0) pattern = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 399) == 0) enable = ~enable;
         reset = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
